// File: rtl/platform_field.sv
// Platform set for the game field: horizontal bounce, vertical scroll and wrap-to-top respawn.
// Optional randomised respawn X is enabled by defining PLATFORM_LFSR_RESPAWN_EN.
module platform_field #(
    parameter int                   NUM_PLAT   = 8,
    parameter int                   COORD_W    = 10,
    parameter int                   X_MIN      = 80,
    parameter int                   X_MAX      = 239,
    parameter int                   Y_MAX      = 239,
    parameter int                   PLAT_HALF  = 20,
    parameter int                   X_STEP     = 15,
    parameter int                   Y_SPACING  = 30,
    parameter int                   X_SPEED    = 2,
    parameter logic [NUM_PLAT-1:0]  MOVER_MASK = 'hA5,
    parameter logic [15:0]          LFSR_SEED  = 16'hACE1
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_clk,
    input  logic                           scroll_valid,
    input  logic [COORD_W-1:0]             scroll_dist,
    output logic                           scroll_ready,
    output logic [NUM_PLAT*COORD_W-1:0]    Platform_X_out,
    output logic [NUM_PLAT*COORD_W-1:0]    Platform_Y_out,
    output logic [NUM_PLAT-1:0]            Platform_dir,
    output logic                           update_busy,
    output logic                           frame_done,
    output logic                           respawn,
    output logic [3:0]                     respawn_idx,
    output logic                           frame_overrun
);

    localparam int IDX_W = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
    localparam logic [COORD_W:0] XL_W    = (COORD_W+1)'(X_MIN + PLAT_HALF);
    localparam logic [COORD_W:0] XR_W    = (COORD_W+1)'(X_MAX - PLAT_HALF);
    localparam logic [COORD_W:0] SPEED_W = (COORD_W+1)'(X_SPEED);
    localparam logic [COORD_W:0] YMAX_W  = (COORD_W+1)'(Y_MAX);
    localparam logic [COORD_W:0] YWRAP_W = (COORD_W+1)'(Y_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [COORD_W-1:0]   pending_q, pending_d;
    logic [COORD_W-1:0]   pass_scroll_q, pass_scroll_d;
    logic [COORD_W-1:0]   x_q [NUM_PLAT];
    logic [COORD_W-1:0]   y_q [NUM_PLAT];
    logic [NUM_PLAT-1:0]  dir_q;
    logic                 respawn_q;
    logic [3:0]           respawn_idx_q;

    logic                 frame_meta_q, frame_sync_q, frame_prev_q;
    logic                 frame_tick;
    logic                 last_plat;

    logic [COORD_W-1:0]   cur_x, cur_y, x_new, y_new;
    logic                 cur_dir, dir_new, wrap;
    logic [COORD_W:0]     x_plus, ys, psum;

    // frame_clk is asynchronous: two flops to resynchronise, a third for edge detect.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_meta_q <= 1'b0;
            frame_sync_q <= 1'b0;
            frame_prev_q <= 1'b0;
        end else begin
            frame_meta_q <= frame_clk;
            frame_sync_q <= frame_meta_q;
            frame_prev_q <= frame_sync_q;
        end
    end

    assign frame_tick = frame_sync_q & ~frame_prev_q;
    assign last_plat  = (idx_q == IDX_W'(NUM_PLAT - 1));

    // FSM: state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    state_d = S_PASS;
                    idx_d   = '0;
                end
            end
            S_PASS: begin
                if (last_plat) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    // Scroll handshake: a beat transfers on a cycle where scroll_valid and scroll_ready
    // are both high; ready only in IDLE and never on the tick cycle, so beats land
    // between passes and the pass always sees a stable pass_scroll.
    always_comb begin
        update_busy   = (state_q != S_IDLE);
        frame_done    = (state_q == S_DONE);
        frame_overrun = frame_tick & (state_q != S_IDLE);
        scroll_ready  = (state_q == S_IDLE) & ~frame_tick;
    end

    // Pending scroll accumulation, saturating at the play-area height.
    always_comb begin
        psum          = {1'b0, pending_q} + {1'b0, scroll_dist};
        pending_d     = pending_q;
        pass_scroll_d = pass_scroll_q;
        if ((state_q == S_IDLE) && frame_tick) begin
            pass_scroll_d = pending_q;
            pending_d     = '0;
        end else if (scroll_valid && scroll_ready) begin
            pending_d = (psum > YMAX_W) ? COORD_W'(Y_MAX) : psum[COORD_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pending_q     <= '0;
            pass_scroll_q <= '0;
        end else begin
            pending_q     <= pending_d;
            pass_scroll_q <= pass_scroll_d;
        end
    end

`ifdef PLATFORM_LFSR_RESPAWN_EN
    localparam int SPAN = X_MAX - X_MIN - 2 * PLAT_HALF;

    logic [15:0]        lfsr_q;
    logic               lfsr_fb;
    logic [6:0]         lfsr_r, lfsr_r_adj;
    logic [COORD_W-1:0] respawn_x;

    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_r     = lfsr_q[6:0];
    assign lfsr_r_adj = (int'(lfsr_r) > SPAN) ? (lfsr_r - 7'(SPAN)) : lfsr_r;
    assign respawn_x  = COORD_W'(X_MIN + PLAT_HALF) + COORD_W'(lfsr_r_adj);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end
`endif

    // Per-platform update for the platform selected by idx_q.
    always_comb begin
        cur_x   = x_q[idx_q];
        cur_y   = y_q[idx_q];
        cur_dir = dir_q[idx_q];
        x_plus  = {1'b0, cur_x} + SPEED_W;
        x_new   = cur_x;
        dir_new = cur_dir;
        if (MOVER_MASK[idx_q]) begin
            if (!cur_dir) begin
                if (x_plus > XR_W) begin
                    x_new   = XR_W[COORD_W-1:0];
                    dir_new = 1'b1;
                end else begin
                    x_new = x_plus[COORD_W-1:0];
                end
            end else begin
                if ({1'b0, cur_x} < (XL_W + SPEED_W)) begin
                    x_new   = XL_W[COORD_W-1:0];
                    dir_new = 1'b0;
                end else begin
                    x_new = cur_x - COORD_W'(X_SPEED);
                end
            end
        end
        ys    = {1'b0, cur_y} + {1'b0, pass_scroll_q};
        wrap  = (ys > YMAX_W);
        y_new = wrap ? COORD_W'(ys - YWRAP_W) : ys[COORD_W-1:0];
`ifdef PLATFORM_LFSR_RESPAWN_EN
        if (wrap) begin
            x_new = respawn_x;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                x_q[i] <= COORD_W'(X_MIN + PLAT_HALF + i * X_STEP);
                y_q[i] <= COORD_W'(Y_MAX - i * Y_SPACING);
            end
            dir_q         <= '0;
            respawn_q     <= 1'b0;
            respawn_idx_q <= '0;
        end else begin
            respawn_q <= 1'b0;
            if (state_q == S_PASS) begin
                x_q[idx_q]   <= x_new;
                y_q[idx_q]   <= y_new;
                dir_q[idx_q] <= dir_new;
                if (wrap) begin
                    respawn_q     <= 1'b1;
                    respawn_idx_q <= 4'(idx_q);
                end
            end
        end
    end

    always_comb begin
        Platform_X_out = '0;
        Platform_Y_out = '0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            Platform_X_out[i*COORD_W +: COORD_W] = x_q[i];
            Platform_Y_out[i*COORD_W +: COORD_W] = y_q[i];
        end
    end

    assign Platform_dir = dir_q;
    assign respawn      = respawn_q;
    assign respawn_idx  = respawn_idx_q;

endmodule

// File: tb/tb_platform_field.sv
// Directed bench for platform_field: reset, scroll/wrap, bounce, saturation, overrun, mid-pass reset.
module tb_platform_field;
    localparam int NP = 8;
    localparam int CW = 10;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               frame_clk;
    logic               scroll_valid;
    logic [CW-1:0]      scroll_dist;
    logic               scroll_ready;
    logic [NP*CW-1:0]   Platform_X_out;
    logic [NP*CW-1:0]   Platform_Y_out;
    logic [NP-1:0]      Platform_dir;
    logic               update_busy;
    logic               frame_done;
    logic               respawn;
    logic [3:0]         respawn_idx;
    logic               frame_overrun;

    platform_field dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .scroll_valid   (scroll_valid),
        .scroll_dist    (scroll_dist),
        .scroll_ready   (scroll_ready),
        .Platform_X_out (Platform_X_out),
        .Platform_Y_out (Platform_Y_out),
        .Platform_dir   (Platform_dir),
        .update_busy    (update_busy),
        .frame_done     (frame_done),
        .respawn        (respawn),
        .respawn_idx    (respawn_idx),
        .frame_overrun  (frame_overrun)
    );

    // clock / watchdog
    always #10 Clk = ~Clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // event monitor: only this block writes the counters
    int            resp_cnt  = 0;
    int            last_idx  = 0;
    int            busy_cnt  = 0;
    int            ready_bad = 0;
    int            ovr_cnt   = 0;
    int            rx_bad    = 0;
    logic [CW-1:0] mon_rx;

    always @(negedge Clk) begin
        if (respawn) begin
            resp_cnt = resp_cnt + 1;
            last_idx = int'(respawn_idx);
            mon_rx   = Platform_X_out[int'(respawn_idx)*CW +: CW];
            if (mon_rx < 10'd100 || mon_rx > 10'd219) rx_bad = rx_bad + 1;
        end
        if (update_busy) begin
            busy_cnt = busy_cnt + 1;
            if (scroll_ready) ready_bad = ready_bad + 1;
        end
        if (frame_overrun) ovr_cnt = ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [NP*CW-1:0] obs, input logic [NP*CW-1:0] exp);
        chk_cnt = chk_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [CW-1:0] px(input int k);
        return Platform_X_out[k*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] py(input int k);
        return Platform_Y_out[k*CW +: CW];
    endfunction

    // driver tasks
    task automatic do_reset();
        @(negedge Clk);
        Reset        = 1'b1;
        frame_clk    = 1'b0;
        scroll_valid = 1'b0;
        scroll_dist  = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic send_scroll(input logic [CW-1:0] d);
        @(negedge Clk);
        check("scroll_ready_idle", scroll_ready, 1);
        scroll_valid = 1'b1;
        scroll_dist  = d;
        @(negedge Clk);
        scroll_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge Clk);
            if (frame_done) got = 1'b1;
        end
        check("frame_done_seen", got, 1);
    endtask

    task automatic run_frame();
        frame_clk = 1'b1;
        wait_done();
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic wait_busy();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge Clk);
            if (update_busy) got = 1'b1;
        end
        check("busy_seen", got, 1);
    endtask

    logic [NP*CW-1:0] rst_x, rst_y;
    int b_resp, b_busy, b_ovr, b_rdy, b_rx;

    initial begin
        Reset        = 1'b1;
        frame_clk    = 1'b0;
        scroll_valid = 1'b0;
        scroll_dist  = '0;
        for (int i = 0; i < NP; i++) begin
            rst_x[i*CW +: CW] = CW'(100 + 15 * i);
            rst_y[i*CW +: CW] = CW'(239 - 30 * i);
        end

        // reset state
        do_reset();
        check("rst_x", Platform_X_out, rst_x);
        check("rst_y", Platform_Y_out, rst_y);
        check("rst_dir", Platform_dir, 0);
        check("rst_ready", scroll_ready, 1);
        check("rst_busy", update_busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_respawn", respawn, 0);
        check("rst_ovr", frame_overrun, 0);

        // scroll 20: P0 wraps 259-240=19, P1 to 229, movers step +2
        send_scroll(10'd20);
        b_resp = resp_cnt; b_busy = busy_cnt;
        run_frame();
        check("s20_y0", py(0), 19);
        check("s20_y1", py(1), 229);
        check("s20_y7", py(7), 49);
        check("s20_x0", px(0), 102);
        check("s20_x1", px(1), 115);
        check("s20_resp_cnt", resp_cnt - b_resp, 1);
        check("s20_resp_idx", last_idx, 0);
        check("s20_busy_len", busy_cnt - b_busy, 9);

        // P7 bounce against the right edge
        do_reset();
        for (int f = 0; f < 7; f++) run_frame();
        check("b7_x7", px(7), 219);
        check("b7_dir7", Platform_dir[7], 0);
        check("b7_x1", px(1), 115);
        check("b7_y7", py(7), 29);
        run_frame();
        check("b8_x7", px(7), 219);
        check("b8_dir7", Platform_dir[7], 1);
        run_frame();
        check("b9_x7", px(7), 217);
        check("b9_dir7", Platform_dir[7], 1);
        check("b9_x0", px(0), 118);
        check("b9_dir1", Platform_dir[1], 0);

        // saturating pending: 200+100 -> 239, every platform wraps to 238-30i
        do_reset();
        send_scroll(10'd200);
        send_scroll(10'd100);
        b_resp = resp_cnt;
        run_frame();
        check("sat_y0", py(0), 238);
        check("sat_y3", py(3), 148);
        check("sat_y7", py(7), 28);
        check("sat_resp_cnt", resp_cnt - b_resp, 8);
        check("sat_resp_last", last_idx, 7);
`ifndef PLATFORM_LFSR_RESPAWN_EN
        check("sat_x0", px(0), 102);
        check("sat_x1", px(1), 115);
`endif

        // second frame edge during a pass, scroll offered while busy
        do_reset();
        b_busy = busy_cnt; b_ovr = ovr_cnt; b_rdy = ready_bad;
        frame_clk = 1'b1;
        wait_busy();
        frame_clk    = 1'b0;
        scroll_valid = 1'b1;
        scroll_dist  = 10'd50;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b1;
        wait_done();
        scroll_valid = 1'b0;
        frame_clk    = 1'b0;
        repeat (15) @(negedge Clk);
        check("ovr_pulses", ovr_cnt - b_ovr, 1);
        check("ovr_single_pass", busy_cnt - b_busy, 9);
        check("ovr_ready_busy", ready_bad - b_rdy, 0);
        run_frame();
        check("ovr_y0_noscroll", py(0), 239);
        check("ovr_y1_noscroll", py(1), 209);

        // reset in the middle of a pass
        do_reset();
        frame_clk = 1'b1;
        wait_busy();
        repeat (3) @(negedge Clk);
        Reset     = 1'b1;
        frame_clk = 1'b0;
        @(negedge Clk);
        check("mrst_x", Platform_X_out, rst_x);
        check("mrst_y", Platform_Y_out, rst_y);
        check("mrst_dir", Platform_dir, 0);
        check("mrst_busy", update_busy, 0);
        check("mrst_done", frame_done, 0);
        check("mrst_respawn", respawn, 0);
        check("mrst_idx", respawn_idx, 0);
        check("mrst_ovr", frame_overrun, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("mrst_ready", scroll_ready, 1);

`ifdef PLATFORM_LFSR_RESPAWN_EN
        // random respawn X must stay in the legal centre range
        do_reset();
        b_resp = resp_cnt; b_rx = rx_bad;
        for (int f = 0; f < 300 && (resp_cnt - b_resp) < 1000; f++) begin
            send_scroll(10'd239);
            run_frame();
        end
        check("lfsr_wraps", ((resp_cnt - b_resp) >= 1000), 1);
        check("lfsr_x_range", rx_bad - b_rx, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
